bcd_seg_scan: RTL and testbench
===============================

Name: bcd_seg_scan

Overview:
Multiplexed 4-digit 7-segment display driver that consumes two registered 2-digit BCD bytes, e.g. operand/result, each 0..81 plus the 8'hBB error code from the binary-to-BCD stage. Latches new values on a load strobe and applies them only at a frame boundary, so the display never tears. Scans the digits at a divided rate and supports leading-zero blanking, per-digit blinking and error display. Sits directly downstream of the BCD decode stage and drives the board anode/segment pins.

Parameters:
CLK_DIV, 50000, clk cycles per scan tick (one digit slot); must be >=2
BLINK_DIV, 250, scan ticks per blink half-period; must be >=1
SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (0 lights a segment)
AN_ACTIVE_LOW, 1, 1 = an outputs inverted (0 enables a digit)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
bcd_a  in  8  left pair, {tens,units} BCD; 8'hBB = error
bcd_b  in  8  right pair, same encoding
load  in  1  1-cycle strobe; capture bcd_a/bcd_b into shadow
lz_blank  in  1  1 = blank the tens digit of a pair when it is 0 and the byte is valid
blink_en  in  4  per-digit blink enable, bit i = digit i
an  out  4  digit enables, an[0] rightmost
seg  out  8  {dp,g,f,e,d,c,b,a}
frame_done  out  1  1-cycle pulse when digit index wraps 3->0

Behaviour:
- Reset (async assert, sync-free release): prescaler=0, digit idx=0, blink phase=0, shadow=active=8'h00 for both pairs, pending=0; an=all off (4'hF if AN_ACTIVE_LOW); seg=all off (8'hFF if SEG_ACTIVE_LOW); frame_done=0.
- Prescaler counts 0..CLK_DIV-1. The tick is the cycle at which the count equals CLK_DIV-1, then the count wraps to 0.
- On tick: idx <= idx+1 mod 4. When idx==3 at tick, this is the frame boundary: frame_done=1 on the next cycle, for exactly 1 cycle.
- Blink counter increments per tick. Reaching BLINK_DIV-1 wraps it to 0 and toggles the phase.
- Load: shadow <= {bcd_a,bcd_b}, pending <= 1. A later load before the boundary overwrites the shadow (last wins).
- Boundary with pending=1: active <= shadow, pending <= 0. If load coincides with the boundary, active <= the incoming bcd_a/bcd_b directly and pending <= 0.
- Digit mapping: idx0 = active_b[3:0], idx1 = active_b[7:4], idx2 = active_a[3:0], idx3 = active_a[7:4].
- Pair invalid if either nibble >9 (this covers 8'hBB). Both digits of an invalid pair show a dash (g only); lz_blank is ignored for it.
- Valid pair with tens==0 and lz_blank=1: tens digit is dark (an off).
- blink_en[idx]=1 and phase=1: digit dark.
- Segment codes, active-high form, bits gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F dash=40. dp is always off. Inverted when SEG_ACTIVE_LOW.
- an and seg are registered and update on the cycle after the tick, from the new idx. Exactly one an is active unless the digit is dark, in which case all are off.
- Latency: a load is visible no later than the first tick after the next frame boundary plus 1 cycle.

Decomposition:
- Package seg_pkg: segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF, ERR_BYTE=8'hBB, NUM_DIGITS=4.
- Sub-module bcd_to_seg7: combinational, nibble + dash flag -> 7-bit active-high pattern, instantiated once on the muxed digit.

Test Plan:
(CLK_DIV=4, BLINK_DIV=2, active-low outputs)
- Reset mid-scan: assert rst_n=0 -> an=4'hF, seg=8'hFF, frame_done=0 immediately. Release -> first an=4'b1101 (idx1) appears 4 cycles later.
- load bcd_a=8'h81, bcd_b=8'h09, lz_blank=1: after the next boundary, one frame shows idx0 seg=~6F, idx1 dark, idx2 seg=~06, idx3 seg=~7F, with an walking 1110/1111/1011/0111.
- load bcd_a=8'hBB, bcd_b=8'h00, lz_blank=0: idx2/idx3 seg=~40 (dash), idx0/idx1 seg=~3F. Repeat with lz_blank=1 -> idx1 dark, idx2/idx3 still dash.
- Tear check: load 8'h12 mid-frame, then load 8'h34 before the boundary -> the current frame keeps the old digits, and the next frame shows 3,4 (last wins). Load at exactly the boundary cycle -> that value is displayed in the next frame.
- blink_en=4'b0001: digit 0 dark on alternate 2-tick windows, other digits unaffected.
- frame_done: count pulses over 64 cycles -> exactly 4 pulses, each 1 cycle wide, spaced 16 cycles apart.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared 7-segment patterns and display constants
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] ERR_BYTE = 8'hBB;

  // Active-high patterns, bit order gfedcba.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic logic pair_invalid(input logic [7:0] pair);
    return (pair[7:4] > 4'd9) || (pair[3:0] > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD nibble (or dash) to active-high gfedcba pattern
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    if (i_dash) begin
      o_seg = SEG_DASH;
    end else begin
      case (i_nibble)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - tear-free multiplexed 4-digit 7-segment scanner
module bcd_seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_DIV      = 250,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bcd_a,
  input  logic [7:0] bcd_b,
  input  logic       load,
  input  logic       lz_blank,
  input  logic [3:0] blink_en,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [7:0] SEG_PIN_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_blk_cnt;
  logic          r_phase;
  logic [15:0]   r_shadow;
  logic [15:0]   r_active;
  logic          r_pending;
  logic          r_frame_done;
  logic [3:0]    r_an;
  logic [7:0]    r_seg;

  logic          w_tick;
  logic          w_boundary;
  logic [1:0]    w_idx_n;
  logic [BW-1:0] w_blk_cnt_n;
  logic          w_phase_n;
  logic [15:0]   w_active_n;
  logic          w_pending_n;
  logic [7:0]    w_pair;
  logic [3:0]    w_nibble;
  logic          w_invalid;
  logic          w_dark;
  logic [6:0]    w_pat;
  logic [3:0]    w_an_n;
  logic [7:0]    w_seg_n;

  assign w_tick     = (r_pre == PRE_MAX);
  assign w_boundary = w_tick && (r_idx == 2'd3);

  // The display registers are loaded with next-state values, so a digit,
  // a blink phase or a frame swap all appear together on the cycle after the tick.
  always_comb begin
    w_idx_n     = w_tick ? r_idx + 2'd1 : r_idx;
    w_blk_cnt_n = r_blk_cnt;
    w_phase_n   = r_phase;
    if (w_tick) begin
      if (r_blk_cnt == BLK_MAX) begin
        w_blk_cnt_n = '0;
        w_phase_n   = ~r_phase;
      end else begin
        w_blk_cnt_n = r_blk_cnt + 1'b1;
      end
    end
    w_active_n  = r_active;
    w_pending_n = r_pending;
    if (w_boundary) begin
      w_pending_n = 1'b0;
      if (load) begin
        w_active_n = {bcd_a, bcd_b};
      end else if (r_pending) begin
        w_active_n = r_shadow;
      end
    end else if (load) begin
      w_pending_n = 1'b1;
    end
  end

  always_comb begin
    w_pair    = w_idx_n[1] ? w_active_n[15:8] : w_active_n[7:0];
    w_nibble  = w_idx_n[0] ? w_pair[7:4] : w_pair[3:0];
    w_invalid = pair_invalid(w_pair);
    w_dark    = (!w_invalid && w_idx_n[0] && lz_blank && (w_pair[7:4] == 4'd0))
             || (blink_en[w_idx_n] && w_phase_n);
    w_an_n    = AN_OFF;
    w_seg_n   = SEG_PIN_OFF;
    if (!w_dark) begin
      w_an_n  = (AN_ACTIVE_LOW != 0) ? ~(4'b0001 << w_idx_n) : (4'b0001 << w_idx_n);
      w_seg_n = (SEG_ACTIVE_LOW != 0) ? ~{1'b0, w_pat} : {1'b0, w_pat};
    end
  end

  bcd_to_seg7 u_dec (
    .i_nibble (w_nibble),
    .i_dash   (w_invalid),
    .o_seg    (w_pat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre        <= '0;
      r_idx        <= 2'd0;
      r_blk_cnt    <= '0;
      r_phase      <= 1'b0;
      r_shadow     <= 16'h0000;
      r_active     <= 16'h0000;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_an         <= AN_OFF;
      r_seg        <= SEG_PIN_OFF;
    end else begin
      r_pre        <= w_tick ? '0 : r_pre + 1'b1;
      r_idx        <= w_idx_n;
      r_blk_cnt    <= w_blk_cnt_n;
      r_phase      <= w_phase_n;
      r_active     <= w_active_n;
      r_pending    <= w_pending_n;
      r_frame_done <= w_boundary;
      if (load) begin
        r_shadow <= {bcd_a, bcd_b};
      end
      if (w_tick) begin
        r_an  <= w_an_n;
        r_seg <= w_seg_n;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb/tb_bcd_seg_scan.sv - scoreboard bench for bcd_seg_scan (CLK_DIV=4, BLINK_DIV=2)
module tb_bcd_seg_scan;

  typedef struct {
    int         slot;
    logic [3:0] an;
    logic [7:0] seg;
    bit         dark;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bcd_a = 8'h00;
  logic [7:0] bcd_b = 8'h00;
  logic       load = 1'b0;
  logic       lz_blank = 1'b0;
  logic [3:0] blink_en = 4'h0;
  logic [3:0] an;
  logic [7:0] seg;
  logic       frame_done;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc;
  exp_t q[$];
  int   fd_cyc[$];
  int   fd_hi = 0;

  bcd_seg_scan #(
    .CLK_DIV(4), .BLINK_DIV(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bcd_a(bcd_a), .bcd_b(bcd_b), .load(load),
    .lz_blank(lz_blank), .blink_en(blink_en), .an(an), .seg(seg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push(input int slot, input logic [3:0] a, input logic [7:0] s);
    exp_t e;
    e.slot = slot; e.an = a; e.seg = s; e.dark = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_dark(input int slot);
    exp_t e;
    e.slot = slot; e.an = 4'hF; e.seg = 8'hFF; e.dark = 1'b1;
    q.push_back(e);
  endtask

  task automatic goto_edge(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [7:0] a, input logic [7:0] b);
    bcd_a = a; bcd_b = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Monitor: a new digit slot is presented after every 4th edge.
  always @(negedge clk) begin
    if (rst_n && cyc > 0 && (cyc % 4) == 0) begin
      while (q.size() > 0 && q[0].slot <= cyc / 4) begin
        exp_t e;
        e = q.pop_front();
        n_tests++;
        if (e.slot < cyc / 4) begin
          n_fail++;
          $display("FAIL slot%0d missed at slot %0d", e.slot, cyc / 4);
        end else if (an !== e.an || (!e.dark && seg !== e.seg)) begin
          n_fail++;
          $display("FAIL slot%0d: got an=%b seg=%h want an=%b seg=%h%s",
                   e.slot, an, seg, e.an, e.seg, e.dark ? " (dark)" : "");
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cyc >= 144 && cyc < 208 && frame_done === 1'b1) begin
      fd_hi++;
      fd_cyc.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_an", {28'd0, an}, 32'hF);
    check("reset_seg", {24'd0, seg}, 32'hFF);
    check("reset_fd", {31'd0, frame_done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    goto_edge(11);
    check("prereset_an_lit", {31'd0, an != 4'hF}, 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_an", {28'd0, an}, 32'hF);
    check("midreset_seg", {24'd0, seg}, 32'hFF);
    check("midreset_fd", {31'd0, frame_done}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First slot after release: idx1 showing '0' (lz_blank off).
    push(1, 4'b1101, 8'hC0);

    // 81/09 with blanking; current frame keeps old digits.
    goto_edge(6);
    lz_blank = 1'b1;
    push(2, 4'b1011, 8'hC0);
    push(4, 4'b1110, 8'h90);
    push_dark(5);
    push(6, 4'b1011, 8'hF9);
    push(7, 4'b0111, 8'h80);
    pulse_load(8'h81, 8'h09);

    // Error byte on the left pair, no blanking.
    goto_edge(30);
    lz_blank = 1'b0;
    push(8, 4'b1110, 8'hC0);
    push(9, 4'b1101, 8'hC0);
    push(10, 4'b1011, 8'hBF);
    push(11, 4'b0111, 8'hBF);
    pulse_load(8'hBB, 8'h00);

    goto_edge(46);
    lz_blank = 1'b1;
    push(12, 4'b1110, 8'hC0);
    push_dark(13);
    push(14, 4'b1011, 8'hBF);
    push(15, 4'b0111, 8'hBF);

    // Two loads in one frame: old digits stay, last load wins.
    goto_edge(66);
    push_dark(17);
    push(18, 4'b1011, 8'hBF);
    push(19, 4'b0111, 8'hBF);
    push(20, 4'b1110, 8'h99);
    push(21, 4'b1101, 8'hB0);
    push(22, 4'b1011, 8'hC0);
    push_dark(23);
    pulse_load(8'h00, 8'h12);
    goto_edge(74);
    pulse_load(8'h00, 8'h34);

    // Load exactly on the boundary edge.
    goto_edge(96);
    push(24, 4'b1110, 8'h82);
    push(25, 4'b1101, 8'h92);
    push(26, 4'b1011, 8'h80);
    push(27, 4'b0111, 8'hF8);
    pulse_load(8'h78, 8'h56);

    // Blink: phase is 1 on ticks k with k%4 in {2,3}.
    goto_edge(110);
    blink_en = 4'b0001;
    push(28, 4'b1110, 8'h82);
    push(31, 4'b0111, 8'hF8);
    goto_edge(126);
    blink_en = 4'b1100;
    push(32, 4'b1110, 8'h82);
    push(33, 4'b1101, 8'h92);
    push_dark(34);
    push_dark(35);
    goto_edge(142);
    blink_en = 4'b0000;

    goto_edge(212);
    check("fd_pulses", fd_cyc.size(), 32'd4);
    check("fd_high_cycles", fd_hi, 32'd4);
    if (fd_cyc.size() == 4) begin
      check("fd_first_aligned", fd_cyc[0] % 16, 32'd0);
      for (int i = 1; i < 4; i++) check("fd_spacing", fd_cyc[i] - fd_cyc[i-1], 32'd16);
    end
    check("scoreboard_drained", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
